cp0_int_ctrl: RTL and testbench

- Interrupt controller in front of the CP0 ExternalInterrupt[5:0] input.
- Synchronises the six raw interrupt lines (timer, buttons S1–S5) and latches them as pending.
- Applies a software mask and per-source edge/level mode, picks one winner by fixed priority, and holds a single one-hot request to CP0 until CP0 accepts it.
- Blocks further requests until the handler returns via eret.

---
 rtl/cp0_int_ctrl_pkg.sv | 28 ++
 rtl/cp0_int_ctrl_if.sv | 26 ++
 rtl/cp0_int_ctrl_irq_sync_edge.sv | 29 ++
 rtl/cp0_int_ctrl.sv | 139 +++++++++++++
 tb/tb_cp0_int_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_int_ctrl_pkg.sv
// Shared types and constants for the CP0 external interrupt controller.
package cp0_int_ctrl_pkg;

   // Controller FSM; the encoding is visible to software in STATUS[1:0].
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } int_state_e;

   // Configuration register select values.
   localparam logic [1:0] ADDR_MASK    = 2'd0;
   localparam logic [1:0] ADDR_MODE    = 2'd1;
   localparam logic [1:0] ADDR_PENDING = 2'd2;
   localparam logic [1:0] ADDR_STATUS  = 2'd3;

   // Source indices, in CP0 ExternalInterrupt bit order (lowest = highest priority).
   localparam int SRC_TIMER  = 0;
   localparam int SRC_BTN_S1 = 1;
   localparam int SRC_BTN_S2 = 2;
   localparam int SRC_BTN_S3 = 3;
   localparam int SRC_BTN_S4 = 4;
   localparam int SRC_BTN_S5 = 5;

   // Width of the in-service index field in STATUS[10:8].
   localparam int ISR_ID_W = 3;

endpackage

// File: rtl/cp0_int_ctrl_if.sv
// CP0-side handshake and configuration bus of the interrupt controller.
interface cp0_int_ctrl_if #(
   parameter int NUM_SRC = 6
);
   logic               cp0_ie;
   logic               int_ack;
   logic               eret;
   logic               cfg_wen;
   logic [1:0]         cfg_addr;
   logic [31:0]        cfg_wdata;
   logic [31:0]        cfg_rdata;
   logic               int_req;
   logic [NUM_SRC-1:0] int_vector;

   // CP0 / software side.
   modport master (
      output cp0_ie, int_ack, eret, cfg_wen, cfg_addr, cfg_wdata,
      input  cfg_rdata, int_req, int_vector
   );

   // Interrupt controller side.
   modport slave (
      input  cp0_ie, int_ack, eret, cfg_wen, cfg_addr, cfg_wdata,
      output cfg_rdata, int_req, int_vector
   );
endinterface

// File: rtl/cp0_int_ctrl_irq_sync_edge.sv
// Per-line synchroniser followed by a history flop for rising-edge detection.
module irq_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic irq,
   output logic lvl,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   // Shift the raw line through the synchroniser chain, then into the history flop.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], irq};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign lvl  = sync_q[SYNC_STAGES-1];
   assign rise = lvl & ~hist_q;

endmodule

// File: rtl/cp0_int_ctrl.sv
// Interrupt controller in front of CP0 ExternalInterrupt: sync, latch, mask,
// fixed-priority pick, and a single non-nesting request held until ack.
module cp0_int_ctrl
   import cp0_int_ctrl_pkg::*;
#(
   parameter int NUM_SRC     = 6,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq_in,
   cp0_int_ctrl_if.slave      bus
);

   logic [NUM_SRC-1:0]  lvl, rise;
   logic [NUM_SRC-1:0]  mask_q, mode_q, pend_q, pend_d;
   logic [NUM_SRC-1:0]  cand, win, w1c, ack_clr;
   logic [NUM_SRC-1:0]  vec_q, vec_d;
   logic [ISR_ID_W-1:0] isr_q, isr_d, vec_idx;
   int_state_e          state_q, state_d;
   logic                wr_mask, wr_mode, wr_pend, took;
   logic                unused_wdata;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clock (clock),
         .reset (reset),
         .irq   (irq_in[i]),
         .lvl   (lvl[i]),
         .rise  (rise[i])
      );
   end

   assign wr_mask = bus.cfg_wen && (bus.cfg_addr == ADDR_MASK);
   assign wr_mode = bus.cfg_wen && (bus.cfg_addr == ADDR_MODE);
   assign wr_pend = bus.cfg_wen && (bus.cfg_addr == ADDR_PENDING);
   assign took    = (state_q == ST_REQ) && bus.int_ack;

   // Only the low NUM_SRC bits of write data are meaningful.
   assign unused_wdata = ^bus.cfg_wdata[31:NUM_SRC];

   // W1C and ack-clear only touch edge-mode sources; level sources track the line.
   assign w1c     = wr_pend ? (bus.cfg_wdata[NUM_SRC-1:0] & mode_q) : '0;
   assign ack_clr = took ? (vec_q & mode_q) : '0;

   // A fresh edge beats any clear arriving in the same cycle.
   assign pend_d = (mode_q & (rise | (pend_q & ~w1c & ~ack_clr))) | (~mode_q & lvl);

   // Lowest index wins: isolate the least-significant set bit.
   assign cand = pend_q & mask_q;
   assign win  = cand & (-cand);

   // One-hot frozen winner back to its index, recorded on acceptance.
   always_comb begin
      vec_idx = '0;
      for (int i = 0; i < NUM_SRC; i++)
         if (vec_q[i]) vec_idx = ISR_ID_W'(i);
   end

   // Configuration and pending registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mask_q <= '1;
         mode_q <= '1;
         pend_q <= '0;
      end else begin
         if (wr_mask) mask_q <= bus.cfg_wdata[NUM_SRC-1:0];
         if (wr_mode) mode_q <= bus.cfg_wdata[NUM_SRC-1:0];
         pend_q <= pend_d;
      end
   end

   // FSM state, frozen vector and in-service id.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         vec_q   <= '0;
         isr_q   <= '0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         isr_q   <= isr_d;
      end
   end

   // Next-state: arbitrate in IDLE, hold/withdraw/accept in REQ, wait for eret in SERVICE.
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      isr_d   = isr_q;
      case (state_q)
         ST_IDLE: begin
            if ((|cand) && bus.cp0_ie) begin
               state_d = ST_REQ;
               vec_d   = win;
            end
         end
         ST_REQ: begin
            // Ack wins over a simultaneous withdraw: CP0 has already committed.
            if (bus.int_ack) begin
               state_d = ST_SERVICE;
               vec_d   = '0;
               isr_d   = vec_idx;
            end else if (!bus.cp0_ie || !(|(vec_q & mask_q))) begin
               state_d = ST_IDLE;
               vec_d   = '0;
            end
         end
         ST_SERVICE: begin
            if (bus.eret) begin
               state_d = ST_IDLE;
               isr_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            vec_d   = '0;
            isr_d   = '0;
         end
      endcase
   end

   // Request is decoded from the state flop so an async reset drops it at once.
   assign bus.int_req    = (state_q == ST_REQ);
   assign bus.int_vector = vec_q;

   // Combinational register read.
   always_comb begin
      bus.cfg_rdata = '0;
      case (bus.cfg_addr)
         ADDR_MASK:    bus.cfg_rdata = {{(32-NUM_SRC){1'b0}}, mask_q};
         ADDR_MODE:    bus.cfg_rdata = {{(32-NUM_SRC){1'b0}}, mode_q};
         ADDR_PENDING: bus.cfg_rdata = {{(32-NUM_SRC){1'b0}}, pend_q};
         ADDR_STATUS:  bus.cfg_rdata = {21'b0, isr_q, 6'b0, state_q};
         default:      bus.cfg_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Scoreboard bench for cp0_int_ctrl: expectations are queued as stimulus is
// applied and compared against DUT observations at the end of each scenario.
module tb_cp0_int_ctrl;
   import cp0_int_ctrl_pkg::*;

   localparam int NUM_SRC = 6;

   typedef struct {
      string       name;
      logic [31:0] val;
   } sb_t;

   logic               clock = 1'b0;
   logic               reset = 1'b0;
   logic [NUM_SRC-1:0] irq_in = '0;

   sb_t         exp_q[$];
   logic [31:0] obs_q[$];
   int          n_chk = 0;
   int          n_err = 0;

   cp0_int_ctrl_if #(.NUM_SRC(NUM_SRC)) bus ();

   cp0_int_ctrl #(.NUM_SRC(NUM_SRC), .SYNC_STAGES(2)) dut (
      .clock  (clock),
      .reset  (reset),
      .irq_in (irq_in),
      .bus    (bus.slave)
   );

   always #10 clock = ~clock;

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus.cfg_wen = 1'b1; bus.cfg_addr = a; bus.cfg_wdata = d;
      step(1);
      bus.cfg_wen = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      bus.cfg_addr = a;
      #1;
      d = bus.cfg_rdata;
   endtask

   task automatic expect_val(input string n, input logic [31:0] v);
      sb_t e;
      e.name = n; e.val = v;
      exp_q.push_back(e);
   endtask

   task automatic pulse_ack();
      bus.int_ack = 1'b1; step(1); bus.int_ack = 1'b0;
   endtask

   task automatic pulse_eret();
      bus.eret = 1'b1; step(1); bus.eret = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] r; sb_t e; logic [31:0] o;
      expect_val("rst_mask", 32'h3F); expect_val("rst_mode", 32'h3F);
      expect_val("rst_pend", 32'h0);  expect_val("rst_status", 32'h0);
      expect_val("rst_req", 32'h0);   expect_val("rst_vec", 32'h0);
      step(3);
      rd(ADDR_MASK, r); obs_q.push_back(r);
      rd(ADDR_MODE, r); obs_q.push_back(r);
      rd(ADDR_PENDING, r); obs_q.push_back(r);
      rd(ADDR_STATUS, r); obs_q.push_back(r);
      obs_q.push_back(32'(bus.int_req)); obs_q.push_back(32'(bus.int_vector));
      step(1);
      reset = 1'b1;
      step(9);
      irq_in[SRC_BTN_S2] = 1'b1;
      expect_val("lat_pend_e2", 32'h00);
      expect_val("lat_pend_e3", 32'h04); expect_val("lat_req_e3", 32'h0);
      expect_val("lat_req_e4", 32'h1);   expect_val("lat_vec_e4", 32'h04);
      step(2); rd(ADDR_PENDING, r); obs_q.push_back(r);
      step(1); rd(ADDR_PENDING, r); obs_q.push_back(r); obs_q.push_back(32'(bus.int_req));
      step(1); obs_q.push_back(32'(bus.int_req)); obs_q.push_back(32'(bus.int_vector));
      expect_val("ack_req", 32'h0); expect_val("ack_status", 32'h0202);
      pulse_ack();
      obs_q.push_back(32'(bus.int_req)); rd(ADDR_STATUS, r); obs_q.push_back(r);
      expect_val("eret_status", 32'h0); expect_val("eret_pend", 32'h0);
      pulse_eret();
      rd(ADDR_STATUS, r); obs_q.push_back(r); rd(ADDR_PENDING, r); obs_q.push_back(r);
      irq_in = '0;
      step(4);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = 32'hDEADBEEF;
         if (obs_q.size() != 0) o = obs_q.pop_front();
         n_chk++;
         if (o !== e.val) begin n_err++; $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, o, e.val); end
      end
   endtask

   task automatic test_priority();
      logic [31:0] r; sb_t e; logic [31:0] o;
      irq_in[SRC_BTN_S3] = 1'b1; irq_in[SRC_BTN_S1] = 1'b1;
      expect_val("prio_req", 32'h1); expect_val("prio_vec", 32'h02);
      step(4); obs_q.push_back(32'(bus.int_req)); obs_q.push_back(32'(bus.int_vector));
      expect_val("prio_pend_after_ack", 32'h08);
      pulse_ack();
      rd(ADDR_PENDING, r); obs_q.push_back(r & 32'h0A);
      expect_val("prio_eret_req", 32'h0); expect_val("prio_rearb_vec", 32'h08);
      pulse_eret(); obs_q.push_back(32'(bus.int_req));
      step(1); obs_q.push_back(32'(bus.int_vector));
      pulse_ack(); pulse_eret();
      irq_in = '0;
      step(4);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = 32'hDEADBEEF;
         if (obs_q.size() != 0) o = obs_q.pop_front();
         n_chk++;
         if (o !== e.val) begin n_err++; $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, o, e.val); end
      end
   endtask

   task automatic test_mask();
      logic [31:0] r; sb_t e; logic [31:0] o;
      wr(ADDR_MASK, 32'h3E);
      irq_in[SRC_TIMER] = 1'b1;
      expect_val("mask_req_off", 32'h0); expect_val("mask_pend", 32'h01);
      step(4); obs_q.push_back(32'(bus.int_req)); rd(ADDR_PENDING, r); obs_q.push_back(r);
      expect_val("unmask_req", 32'h1); expect_val("unmask_vec", 32'h01);
      wr(ADDR_MASK, 32'h3F);
      step(1); obs_q.push_back(32'(bus.int_req)); obs_q.push_back(32'(bus.int_vector));
      pulse_ack(); pulse_eret();
      irq_in = '0;
      step(3);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = 32'hDEADBEEF;
         if (obs_q.size() != 0) o = obs_q.pop_front();
         n_chk++;
         if (o !== e.val) begin n_err++; $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, o, e.val); end
      end
   endtask

   task automatic test_withdraw();
      logic [31:0] r; sb_t e; logic [31:0] o;
      irq_in[SRC_BTN_S4] = 1'b1;
      expect_val("wd_req", 32'h1); expect_val("wd_vec", 32'h10);
      step(4); obs_q.push_back(32'(bus.int_req)); obs_q.push_back(32'(bus.int_vector));
      bus.cp0_ie = 1'b0;
      expect_val("ie_off_req", 32'h0); expect_val("ie_off_vec", 32'h0); expect_val("ie_off_pend", 32'h10);
      step(1); obs_q.push_back(32'(bus.int_req)); obs_q.push_back(32'(bus.int_vector));
      rd(ADDR_PENDING, r); obs_q.push_back(r & 32'h10);
      bus.cp0_ie = 1'b1;
      expect_val("ie_on_req", 32'h1); expect_val("ie_on_vec", 32'h10);
      step(1); obs_q.push_back(32'(bus.int_req)); obs_q.push_back(32'(bus.int_vector));
      expect_val("mask_wd_req", 32'h0); expect_val("mask_wd_pend", 32'h10);
      wr(ADDR_MASK, 32'h2F);
      step(1); obs_q.push_back(32'(bus.int_req)); rd(ADDR_PENDING, r); obs_q.push_back(r & 32'h10);
      expect_val("remask_vec", 32'h10);
      wr(ADDR_MASK, 32'h3F);
      step(1); obs_q.push_back(32'(bus.int_vector));
      pulse_ack(); pulse_eret();
      irq_in = '0;
      step(3);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = 32'hDEADBEEF;
         if (obs_q.size() != 0) o = obs_q.pop_front();
         n_chk++;
         if (o !== e.val) begin n_err++; $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, o, e.val); end
      end
   endtask

   task automatic test_w1c_race();
      logic [31:0] r; sb_t e; logic [31:0] o;
      wr(ADDR_MASK, 32'h3B);
      irq_in[SRC_BTN_S2] = 1'b1;
      expect_val("w1c_pre_pend", 32'h04); expect_val("w1c_pre_req", 32'h0);
      step(3); rd(ADDR_PENDING, r); obs_q.push_back(r); obs_q.push_back(32'(bus.int_req));
      irq_in[SRC_BTN_S2] = 1'b0;
      step(3);
      irq_in[SRC_BTN_S2] = 1'b1;
      step(2);
      // Rise pulse is live in this cycle: the W1C must lose.
      expect_val("w1c_race_pend", 32'h04);
      wr(ADDR_PENDING, 32'h04);
      rd(ADDR_PENDING, r); obs_q.push_back(r);
      expect_val("w1c_plain_pend", 32'h00);
      wr(ADDR_PENDING, 32'h04);
      rd(ADDR_PENDING, r); obs_q.push_back(r);
      wr(ADDR_MASK, 32'h3F);
      irq_in = '0;
      expect_val("w1c_end_req", 32'h0);
      step(3); obs_q.push_back(32'(bus.int_req));
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = 32'hDEADBEEF;
         if (obs_q.size() != 0) o = obs_q.pop_front();
         n_chk++;
         if (o !== e.val) begin n_err++; $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, o, e.val); end
      end
   endtask

   task automatic test_level_and_reset();
      logic [31:0] r; sb_t e; logic [31:0] o;
      wr(ADDR_MODE, 32'h1F);
      irq_in[SRC_BTN_S5] = 1'b1;
      expect_val("lvl_req", 32'h1); expect_val("lvl_vec", 32'h20);
      step(4); obs_q.push_back(32'(bus.int_req)); obs_q.push_back(32'(bus.int_vector));
      expect_val("lvl_status", 32'h0502); expect_val("lvl_pend_svc", 32'h20);
      pulse_ack();
      rd(ADDR_STATUS, r); obs_q.push_back(r); rd(ADDR_PENDING, r); obs_q.push_back(r);
      expect_val("lvl_w1c_ignored", 32'h20);
      wr(ADDR_PENDING, 32'h20);
      rd(ADDR_PENDING, r); obs_q.push_back(r);
      irq_in[SRC_BTN_S5] = 1'b0;
      expect_val("lvl_pend_drop", 32'h0);
      step(3); rd(ADDR_PENDING, r); obs_q.push_back(r);
      expect_val("lvl_eret_status", 32'h0); expect_val("lvl_no_retrig", 32'h0);
      pulse_eret(); rd(ADDR_STATUS, r); obs_q.push_back(r);
      step(3); obs_q.push_back(32'(bus.int_req));
      irq_in[SRC_BTN_S5] = 1'b1;
      expect_val("rst_pre_req", 32'h1);
      step(4); obs_q.push_back(32'(bus.int_req));
      expect_val("rst_async_req", 32'h0); expect_val("rst_async_vec", 32'h0); expect_val("rst_async_mode", 32'h3F);
      reset = 1'b0;
      #1;
      obs_q.push_back(32'(bus.int_req)); obs_q.push_back(32'(bus.int_vector));
      rd(ADDR_MODE, r); obs_q.push_back(r);
      step(2);
      irq_in = '0;
      reset = 1'b1;
      step(4);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = 32'hDEADBEEF;
         if (obs_q.size() != 0) o = obs_q.pop_front();
         n_chk++;
         if (o !== e.val) begin n_err++; $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, o, e.val); end
      end
   endtask

   initial begin
      bus.cp0_ie = 1'b1; bus.int_ack = 1'b0; bus.eret = 1'b0;
      bus.cfg_wen = 1'b0; bus.cfg_addr = ADDR_MASK; bus.cfg_wdata = '0;
      test_reset();
      test_priority();
      test_mask();
      test_withdraw();
      test_w1c_race();
      test_level_and_reset();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
